// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage and its prefetch queue.
package fetch_pkg;

  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched entries with head/tail/count and a synchronous clear.
module fetch_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    push,
  input  logic                    pop,
  input  logic [Width-1:0]        wdata,
  output logic [Width-1:0]        rdata,
  output logic [$clog2(Depth):0]  count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    // Clear only invalidates: storage keeps its stale contents.
    if (clr) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = wdata;
        tail_d        = tail_q + PtrW'(1);
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: sequential PC, prefetch queue feeding decode, flush-and-restart on redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [XLEN-1:0]         imem_addr,
  input  logic [31:0]             imem_rdata,
  input  logic                    imem_ready,
  input  logic                    redirect,
  input  logic [XLEN-1:0]         redirect_pc,
  input  logic                    stall_d,
  output logic                    valid_d,
  output logic [31:0]             instr_d,
  output logic [XLEN-1:0]         pc_d,
  output logic [XLEN-1:0]         pc_plus4_d,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            push, pop, fifo_pop;
  fetch_entry_t    wr_entry, head;

  assign valid_d  = (count != '0);
  assign pop      = valid_d & ~stall_d;
  // A full queue may still accept when the head leaves in the same cycle.
  assign push     = imem_ready & ~redirect & ((count < CntW'(DEPTH)) | pop);
  assign fifo_pop = pop & ~redirect;
  assign wr_entry = '{instr: imem_rdata, pc: fetch_pc_q};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo #(
    .Width (ILEN + XLEN),
    .Depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (redirect),
    .push  (push),
    .pop   (fifo_pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (count)
  );

  assign imem_addr = fetch_pc_q;

  always_comb begin
    instr_d    = NOP_INSTR;
    pc_d       = '0;
    pc_plus4_d = '0;
    if (valid_d) begin
      instr_d    = head.instr;
      pc_d       = head.pc;
      pc_plus4_d = head.pc + XLEN'(4);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue scoreboard plus per-scenario directed checks.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, redirect, stall_d, imem_ready, valid_d;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, instr_d, pc_d, pc_plus4_d;
  logic [2:0]  count;

  logic        rst2, redirect2, stall2, ready2, valid_d2;
  logic [15:0] redirect_pc2, imem_addr2, pc_d2, pc_plus4_d2;
  logic [31:0] imem_rdata2, instr_d2;
  logic [2:0]  count2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata  = instr_of(imem_addr);
  assign imem_rdata2 = {16'hC3C3, imem_addr2};

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall_d(stall_d), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .count(count)
  );

  fetch_queue #(.XLEN(16), .DEPTH(4), .RESET_PC(16'hFFF8)) dut16 (
    .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .imem_ready(ready2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .stall_d(stall2), .valid_d(valid_d2), .instr_d(instr_d2), .pc_d(pc_d2),
    .pc_plus4_d(pc_plus4_d2), .count(count2)
  );

  task automatic model_reset();
    exp_q.delete();
    m_pc = 32'h100;
  endtask

  // One clock: predict this cycle's push/pop, compare the head on pops, then advance.
  task automatic tick();
    int   sz;
    bit   do_pop;
    exp_t e;
    #2;
    sz = exp_q.size();
    n_checks++;
    if (count !== 3'(sz)) begin
      n_fail++; $display("FAIL sb_count: got %0d expected %0d", count, sz);
    end
    n_checks++;
    if (valid_d !== (sz != 0)) begin
      n_fail++; $display("FAIL sb_valid: got %0b expected %0b", valid_d, sz != 0);
    end
    n_checks++;
    if (imem_addr !== m_pc) begin
      n_fail++; $display("FAIL sb_imem_addr: got %h expected %h", imem_addr, m_pc);
    end
    if (redirect) begin
      exp_q.delete();
      m_pc = redirect_pc;
    end else begin
      do_pop = (sz != 0) && !stall_d;
      if (do_pop) begin
        e = exp_q.pop_front();
        n_checks++;
        if (pc_d !== e.pc || instr_d !== e.instr || pc_plus4_d !== e.pc + 32'd4) begin
          n_fail++;
          $display("FAIL sb_head: got pc %h instr %h pc4 %h expected pc %h instr %h pc4 %h",
                   pc_d, instr_d, pc_plus4_d, e.pc, e.instr, e.pc + 32'd4);
        end
      end
      if (imem_ready && (sz < 4 || do_pop)) begin
        exp_q.push_back('{instr: instr_of(m_pc), pc: m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    redirect = 1'b0; redirect_pc = '0; stall_d = 1'b0; imem_ready = 1'b1;
    redirect2 = 1'b0; redirect_pc2 = '0; stall2 = 1'b0; ready2 = 1'b1;
    #1 rst = 1'b0; rst2 = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (valid_d !== 1'b0 || count !== 3'd0 || instr_d !== 32'h13 || pc_d !== 32'h0
        || pc_plus4_d !== 32'h0 || imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL reset_state: got v%0b c%0d i%h pc%h p4%h a%h expected v0 c0 i00000013 pc0 p40 a100",
               valid_d, count, instr_d, pc_d, pc_plus4_d, imem_addr);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (valid_d !== 1'b1 || pc_d !== 32'h100 || pc_plus4_d !== 32'h104 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL first_fetch: got v%0b pc%h p4%h c%0d expected v1 pc100 p4104 c1",
               valid_d, pc_d, pc_plus4_d, count);
    end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_checks++;
      if (pc_d !== 32'h100 + 32'(4 * i) || count !== 3'd1) begin
        n_fail++;
        $display("FAIL stream_%0d: got pc%h c%0d expected pc%h c1", i, pc_d, count,
                 32'h100 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall_fill();
    stall_d = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (count !== 3'd4 || imem_addr !== 32'h128 || pc_d !== 32'h118) begin
      n_fail++;
      $display("FAIL stall_full: got c%0d a%h pc%h expected c4 a128 pc118",
               count, imem_addr, pc_d);
    end
    stall_d = 1'b0;
    tick();
    n_checks++;
    if (count !== 3'd4 || imem_addr !== 32'h12C || pc_d !== 32'h11C) begin
      n_fail++;
      $display("FAIL full_push_pop: got c%0d a%h pc%h expected c4 a12c pc11c",
               count, imem_addr, pc_d);
    end
    imem_ready = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (count !== 3'd0 || valid_d !== 1'b0 || instr_d !== 32'h13 || imem_addr !== 32'h12C) begin
      n_fail++;
      $display("FAIL drain_empty: got c%0d v%0b i%h a%h expected c0 v0 i00000013 a12c",
               count, valid_d, instr_d, imem_addr);
    end
  endtask

  task automatic test_imem_wait();
    logic [3:0] pat;
    pat = 4'b1001;
    stall_d = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      imem_ready = pat[i];
      tick();
    end
    n_checks++;
    if (count !== 3'd2 || pc_d !== 32'h12C || imem_addr !== 32'h134) begin
      n_fail++;
      $display("FAIL imem_wait: got c%0d pc%h a%h expected c2 pc12c a134",
               count, pc_d, imem_addr);
    end
    stall_d = 1'b0; imem_ready = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_redirect();
    stall_d = 1'b1; imem_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (count !== 3'd3) begin
      n_fail++; $display("FAIL redir_prefill: got c%0d expected c3", count);
    end
    stall_d = 1'b0; redirect = 1'b1; redirect_pc = 32'h2000;
    tick();
    n_checks++;
    if (valid_d !== 1'b0 || instr_d !== 32'h13 || count !== 3'd0 || pc_d !== 32'h0
        || imem_addr !== 32'h2000) begin
      n_fail++;
      $display("FAIL redir_flush: got v%0b i%h c%0d pc%h a%h expected v0 i00000013 c0 pc0 a2000",
               valid_d, instr_d, count, pc_d, imem_addr);
    end
    redirect = 1'b0;
    tick();
    n_checks++;
    if (valid_d !== 1'b1 || pc_d !== 32'h2000 || instr_d !== 32'h5A5A2000) begin
      n_fail++;
      $display("FAIL redir_target: got v%0b pc%h i%h expected v1 pc2000 i5a5a2000",
               valid_d, pc_d, instr_d);
    end
    redirect = 1'b1; redirect_pc = 32'h3000;
    tick();
    redirect_pc = 32'h4000;
    tick();
    redirect = 1'b0;
    tick();
    n_checks++;
    if (pc_d !== 32'h4000 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL redir_last_wins: got pc%h c%0d expected pc4000 c1", pc_d, count);
    end
  endtask

  task automatic test_async_reset();
    repeat (2) tick();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (valid_d !== 1'b0 || count !== 3'd0 || instr_d !== 32'h13 || pc_d !== 32'h0
        || pc_plus4_d !== 32'h0 || imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL async_reset: got v%0b c%0d i%h pc%h p4%h a%h expected v0 c0 i00000013 pc0 p40 a100",
               valid_d, count, instr_d, pc_d, pc_plus4_d, imem_addr);
    end
    #1 rst = 1'b1;
    model_reset();
    tick();
    n_checks++;
    if (valid_d !== 1'b1 || pc_d !== 32'h100) begin
      n_fail++;
      $display("FAIL reset_restart: got v%0b pc%h expected v1 pc100", valid_d, pc_d);
    end
  endtask

  task automatic test_wrap16();
    n_checks++;
    if (imem_addr2 !== 16'hFFF8 || valid_d2 !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_reset: got a%h v%0b expected afff8 v0", imem_addr2, valid_d2);
    end
    rst2 = 1'b1;
    tick();
    n_checks++;
    if (valid_d2 !== 1'b1 || pc_d2 !== 16'hFFF8 || pc_plus4_d2 !== 16'hFFFC) begin
      n_fail++;
      $display("FAIL wrap_first: got v%0b pc%h p4%h expected v1 pcfff8 p4fffc",
               valid_d2, pc_d2, pc_plus4_d2);
    end
    tick();
    n_checks++;
    if (pc_d2 !== 16'hFFFC || pc_plus4_d2 !== 16'h0000 || imem_addr2 !== 16'h0000
        || instr_d2 !== 32'hC3C3FFFC) begin
      n_fail++;
      $display("FAIL wrap_edge: got pc%h p4%h a%h i%h expected pcfffc p40000 a0000 ic3c3fffc",
               pc_d2, pc_plus4_d2, imem_addr2, instr_d2);
    end
    tick();
    n_checks++;
    if (pc_d2 !== 16'h0000 || pc_plus4_d2 !== 16'h0004 || count2 !== 3'd1) begin
      n_fail++;
      $display("FAIL wrap_after: got pc%h p4%h c%0d expected pc0000 p40004 c1",
               pc_d2, pc_plus4_d2, count2);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_fill();
    test_imem_wait();
    test_redirect();
    test_async_reset();
    test_wrap16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with a decoupling prefetch queue, replacing the single-register F→D handoff of the current pipeline. Holds the fetch PC, issues sequential fetches to instruction memory, buffers up to DEPTH fetched instructions with their PCs, and presents the oldest to the decode stage under a valid/stall handshake. A redirect from the execute stage (taken branch or jump) flushes the queue and restarts fetch at the target.

## Interface
- XLEN, 32, address/PC width (≥ 16)
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 0, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- imem_addr  out  XLEN  fetch address (equals internal fetch PC)
- imem_rdata  in  32  instruction at imem_addr, combinational, same cycle
- imem_ready  in  1  imem_rdata valid this cycle; 0 = memory wait
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  XLEN  target address; sampled only when redirect=1
- stall_d  in  1  decode not accepting head entry this cycle
- valid_d  out  1  head entry valid
- instr_d  out  32  head instruction; NOP (32'h00000013) when valid_d=0
- pc_d  out  XLEN  head PC; 0 when valid_d=0
- pc_plus4_d  out  XLEN  pc_d + 4, modulo 2^XLEN; 0 when valid_d=0
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- push = imem_ready & ~redirect & (count < DEPTH | pop); writes {imem_rdata, fetch PC} at tail; fetch PC += 4 (wraps modulo 2^XLEN)
- pop = valid_d & ~stall_d; advances head
- valid_d = (count != 0); outputs driven directly from head entry (no bypass of imem_rdata)
- Simultaneous push and pop: count unchanged; legal when full and when count = 1
- Full (count = DEPTH) without pop: no push, fetch PC holds, imem_addr holds
- Empty: valid_d=0, pop impossible regardless of stall_d
- imem_ready=0: no push, fetch PC holds; pop proceeds normally
- redirect=1 (priority over everything): head/tail pointers and count cleared, fetch PC ← redirect_pc, no push, any pop that cycle is discarded; entries are not erased, only invalidated
- Redirect while already empty or repeated on consecutive cycles: last redirect_pc wins
- Pointers log2(DEPTH) bits, wrap naturally; count distinguishes full from empty

## Timing
- Reset (rst=0, asynchronous): fetch PC = RESET_PC, pointers = 0, count = 0, valid_d = 0, instr_d = NOP, pc_d = pc_plus4_d = 0; imem_addr = RESET_PC
- First cycle after rst deasserts: fetch RESET_PC; valid_d=1 with pc_d=RESET_PC next cycle (fetch-to-decode latency 1 cycle)
- Redirect asserted cycle N: valid_d=0 in N+1 (target fetched in N+1), target valid at head in N+2 given imem_ready=1
- Steady state, no stall, imem_ready=1: one instruction per cycle, queue occupancy 1
- Reset asserted mid-operation: immediate return to reset values, no clock needed

## Structure
- Package fetch_pkg: NOP_INSTR constant (32'h00000013), fetch_entry_t typedef {instr[31:0], pc[XLEN-1:0]} (parameterised via the module), ILEN = 32
- One sub-module: fetch_fifo (DEPTH × entry storage, head/tail/count, synchronous clear input driven by redirect); fetch_queue contains PC register, push/pop logic, output gating

## Test plan
- Reset release, RESET_PC=32'h100, stall_d=0, imem_ready=1 -> valid_d=1 one cycle after release, pc_d sequence 0x100, 0x104, 0x108, pc_plus4_d = pc_d+4, count stays 1
- stall_d=1 held 6 cycles, DEPTH=4 -> count reaches 4, imem_addr freezes at head PC+16, no entry lost; release stall -> PCs drain in order, one per cycle
- Full queue, stall_d=0 same cycle imem_ready=1 -> push and pop together, count stays 4, next fetched PC enqueued
- redirect=1 with redirect_pc=32'h2000 while count=3 -> next cycle valid_d=0, instr_d=NOP, count=0; following cycle pc_d=0x2000
- imem_ready toggling 1,0,0,1 -> only two entries pushed, PCs consecutive (no skip, no duplicate)
- rst pulsed low mid-stream between clock edges -> outputs return to reset values immediately; XLEN=16, fetch PC 0xFFFC -> next PC wraps to 0x0000
